regfile_pc: RTL
===============

REGFILE_PC -- requirements
Module: regfile_pc

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every register and of the data bus.
REQ-002 Parameter NREGS, default 8: number of registers; legal range 2..16.
REQ-003 Parameter GP_RESET, default 0: reset value of the general-purpose registers R0..R(NREGS-2).
REQ-004 Parameter PC_RESET, default 0: reset value of the program counter, register R(NREGS-1).
REQ-005 Port Clock, input, 1: sole clock; all state changes on its rising edge.
REQ-006 Port Resetn, input, 1: asynchronous, active-low reset.
REQ-007 Port R, input, WIDTH: write data from the datapath bus.
REQ-008 Port Rin, input, NREGS: one-hot-or-multi write enable from the controller; bit i loads register i.
REQ-009 Port PcIncr, input, 1: advance the program counter by 1.
REQ-010 Port PcClear, input, 1: force the program counter to 0.
REQ-011 Port RdSelA, input, clog2(NREGS): read-port A address.
REQ-012 Port RdSelB, input, clog2(NREGS): read-port B address.
REQ-013 Port QA, output, WIDTH: contents of register RdSelA.
REQ-014 Port QB, output, WIDTH: contents of register RdSelB.
REQ-015 Port Pc, output, WIDTH: current program counter, always visible.
REQ-016 Port PcWrap, output, 1: registered pulse, high one cycle after the program counter wraps from all-ones to 0 by increment.

Function
REQ-017 Each GP register i SHALL load R on a rising Clock edge when Rin[i]=1, and hold otherwise.
REQ-018 Several Rin bits high in one cycle SHALL load R into every selected register.
REQ-019 PC update priority per edge SHALL be PcClear > Rin[NREGS-1] > PcIncr > hold.
REQ-020 PcIncr SHALL add 1 modulo 2^WIDTH; all-ones + 1 SHALL give 0 and set PcWrap on the same edge.
REQ-021 PcWrap SHALL be 0 in every cycle not covered by REQ-020, including when a load or clear pre-empts an increment.
REQ-022 QA and QB SHALL be combinational reads of the current register state, so a write becomes visible on them the cycle after its edge; there is no write-through.
REQ-023 An out-of-range RdSelA or RdSelB (>= NREGS) SHALL return 0.
REQ-024 Rin, PcIncr and PcClear SHALL have no effect while Resetn=0.

Reset
REQ-025 Resetn low SHALL immediately set R0..R(NREGS-2) to GP_RESET, the PC to PC_RESET and PcWrap to 0, without waiting for a clock edge.
REQ-026 Resetn deassertion SHALL be synchronised externally; the first edge after release SHALL honour the inputs normally.
REQ-027 Reset asserted mid-sequence, for example during an increment run, SHALL discard all pending updates.

Structure
REQ-028 WIDTH and NREGS defaults, the PC index constant (NREGS-1) and the select width SHALL live in the shared processor package.
REQ-029 One sub-module, reg_cell, SHALL implement a single enabled WIDTH-bit register with async reset and a reset-value parameter; it SHALL be instantiated NREGS-1 times, and the PC SHALL be coded separately.
REQ-030 The block SHALL contain no latches, and the read muxes SHALL be the only combinational paths to QA and QB.

Verification
REQ-031 Assert Resetn=0 with WIDTH=16, NREGS=8, GP_RESET=2 -> all of R0..R6 read 2, Pc=0, PcWrap=0, with no clock edge needed.
REQ-032 R=16'h00A5 with Rin=8'b0000_0110 for one edge -> R1=R2=16'h00A5 and all other registers unchanged; QA with RdSelA=2 shows 16'h00A5 the next cycle.
REQ-033 Pc=16'hFFFE, then PcIncr held for 2 edges -> Pc=16'hFFFF then 16'h0000, with PcWrap high exactly one cycle after the second edge.
REQ-034 PcIncr=1, Rin[7]=1 and R=16'h0040 on the same edge -> Pc=16'h0040; adding PcClear=1 on the same edge -> Pc=0.
REQ-035 Resetn pulsed low between clock edges mid-increment run -> Pc=PC_RESET immediately, and increments resume from PC_RESET after release.
REQ-036 RdSelA=3'd7 and RdSelB=3'd0 while the PC counts -> QA tracks Pc each cycle and QB holds R0.

Source files
------------

// File: rtl/regfile_pc_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pc_pkg
// Shared processor package for the register file / program counter block.
// Holds the default geometry, the helpers that derive the PC index and the
// read-select width from the register count, and the PC update operation type
// together with its priority decode.
// -----------------------------------------------------------------------------
package regfile_pc_pkg;

   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_NREGS  = 8;
   localparam int unsigned DEF_PC_IDX = DEF_NREGS - 1;
   localparam int unsigned DEF_SEL_W  = $clog2(DEF_NREGS);

   // What the PC does on a given edge.
   typedef enum logic [1:0] {
      PC_HOLD,
      PC_INCR,
      PC_LOAD,
      PC_CLEAR
   } pc_op_e;

   // The program counter is always the highest-numbered register.
   function automatic int unsigned pc_index(input int unsigned nregs);
      return nregs - 1;
   endfunction

   function automatic int unsigned sel_width(input int unsigned nregs);
      return $clog2(nregs);
   endfunction

   // Clear beats a bus load, a bus load beats an increment.
   function automatic pc_op_e pc_decode(input logic clr, input logic ld, input logic inc);
      if (clr)      return PC_CLEAR;
      else if (ld)  return PC_LOAD;
      else if (inc) return PC_INCR;
      else          return PC_HOLD;
   endfunction

endpackage

// File: rtl/regfile_pc_reg_cell.sv
// -----------------------------------------------------------------------------
// reg_cell
// One WIDTH-bit general-purpose register with load enable and asynchronous
// active-low reset to RESET_VAL.
//
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset
//   en     - load enable; d is captured on the edge when high
//   d      - load data
//   q      - register contents
// -----------------------------------------------------------------------------
module reg_cell #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking (<=) so every flop in the design
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_pc.sv
// -----------------------------------------------------------------------------
// regfile_pc
// Register file of NREGS WIDTH-bit registers. R0..R(NREGS-2) are plain
// general-purpose registers; R(NREGS-1) is the program counter, which can also
// be cleared, incremented, or loaded from the bus. Two combinational read ports.
//
// Ports:
//   Clock   - rising-edge clock
//   Resetn  - asynchronous active-low reset
//   R       - write data from the datapath bus
//   Rin     - per-register write enables (several may be high at once)
//   PcIncr  - advance PC by 1 (lowest priority)
//   PcClear - force PC to 0 (highest priority)
//   RdSelA  - read port A address
//   RdSelB  - read port B address
//   QA, QB  - read data; 0 for an address >= NREGS
//   Pc      - current program counter
//   PcWrap  - one-cycle pulse after an increment takes PC from all-ones to 0
// -----------------------------------------------------------------------------
module regfile_pc
   import regfile_pc_pkg::*;
#(
   parameter int unsigned      WIDTH    = DEF_WIDTH,
   parameter int unsigned      NREGS    = DEF_NREGS,  // legal range 2..16
   parameter logic [WIDTH-1:0] GP_RESET = '0,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic                          Clock,
   input  logic                          Resetn,
   input  logic [WIDTH-1:0]              R,
   input  logic [NREGS-1:0]              Rin,
   input  logic                          PcIncr,
   input  logic                          PcClear,
   input  logic [sel_width(NREGS)-1:0]   RdSelA,
   input  logic [sel_width(NREGS)-1:0]   RdSelB,
   output logic [WIDTH-1:0]              QA,
   output logic [WIDTH-1:0]              QB,
   output logic [WIDTH-1:0]              Pc,
   output logic                          PcWrap
);

   localparam int unsigned PC_IDX = pc_index(NREGS);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] pc_q;
   logic             wrap_q;
   pc_op_e           pc_op;

   // NOTE: the file is built from individual flops rather than a RAM, so every
   // entry takes its reset value asynchronously along with the PC.
   for (genvar i = 0; i < NREGS - 1; i++) begin : g_gp
      reg_cell #(
         .WIDTH     (WIDTH),
         .RESET_VAL (GP_RESET)
      ) u_cell (
         .Clock  (Clock),
         .Resetn (Resetn),
         .en     (Rin[i]),
         .d      (R),
         .q      (regs[i])
      );
   end

   assign pc_op = pc_decode(PcClear, Rin[PC_IDX], PcIncr);

   // PcWrap is cleared on every edge and only re-armed by an increment out of
   // all-ones, so a clear or load that pre-empts the increment never pulses it.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pc_q   <= PC_RESET;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (pc_op)
            PC_CLEAR: pc_q <= '0;
            PC_LOAD:  pc_q <= R;
            PC_INCR: begin
               pc_q   <= pc_q + 1'b1;
               wrap_q <= &pc_q;
            end
            default:  pc_q <= pc_q;
         endcase
      end
   end

   assign regs[PC_IDX] = pc_q;
   assign Pc           = pc_q;
   assign PcWrap       = wrap_q;

   // Reads see current state only: a write shows up the cycle after its edge.
   // NOTE: outputs get a default before the conditional so no path leaves them
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      QA = '0;
      QB = '0;
      if (32'(RdSelA) < NREGS) QA = regs[RdSelA];
      if (32'(RdSelB) < NREGS) QB = regs[RdSelB];
   end

endmodule
